// File: rtl/hazard_unit_pkg.sv
// hazard_unit_pkg: shared encodings for the P5 hazard unit.
//   T_USE_NONE        - rs/rt T_use tag meaning "operand not read"
//   fwd_sel_e         - forwarding-mux select codes (GRF/E/M/W)
//   TNEW_*            - decoder T_new tags for the main instruction classes
//   tnew_dec()        - saturating one-stage advance of a T_new counter
package hazard_unit_pkg;

  localparam int unsigned TAG_W = 2;

  localparam logic [TAG_W-1:0] T_USE_NONE = 2'd3;

  localparam logic [TAG_W-1:0] TNEW_LW  = 2'd3;
  localparam logic [TAG_W-1:0] TNEW_ALU = 2'd2;
  localparam logic [TAG_W-1:0] TNEW_JAL = 2'd1;

  typedef enum logic [TAG_W-1:0] {
    FWD_NONE = 2'd0,
    FWD_E    = 2'd1,
    FWD_M    = 2'd2,
    FWD_W    = 2'd3
  } fwd_sel_e;

  // Advance a T_new tag by one pipeline stage, clamping at zero.
  function automatic logic [TAG_W-1:0] tnew_dec(input logic [TAG_W-1:0] t);
    return (t == '0) ? '0 : TAG_W'(t - TAG_W'(1));
  endfunction

endpackage

// File: rtl/hazard_unit_if.sv
// hazard_unit_if: D-stage timing tags in, stall/forward selects out.
//   d_rs, d_rt, d_a3, d_reg_write      - D-stage register fields
//   d_rs_tuse, d_rt_tuse, d_tnew       - decoder timing tags
//   stall                              - freeze PC/F-D, bubble into D/E
//   fwd_d_rs/rt, fwd_e_rs/rt, fwd_m_rt - forwarding-mux selects
//   stall_cnt                          - saturating stall-cycle counter
// master = decoder/datapath side, slave = hazard unit.
interface hazard_unit_if #(
  parameter int unsigned REG_AW = 5,
  parameter int unsigned CNT_W  = 32
);
  logic [REG_AW-1:0] d_rs;
  logic [REG_AW-1:0] d_rt;
  logic [REG_AW-1:0] d_a3;
  logic              d_reg_write;
  logic [1:0]        d_rs_tuse;
  logic [1:0]        d_rt_tuse;
  logic [1:0]        d_tnew;

  logic              stall;
  logic [1:0]        fwd_d_rs;
  logic [1:0]        fwd_d_rt;
  logic [1:0]        fwd_e_rs;
  logic [1:0]        fwd_e_rt;
  logic [1:0]        fwd_m_rt;
  logic [CNT_W-1:0]  stall_cnt;

  modport master (
    output d_rs, d_rt, d_a3, d_reg_write, d_rs_tuse, d_rt_tuse, d_tnew,
    input  stall, fwd_d_rs, fwd_d_rt, fwd_e_rs, fwd_e_rt, fwd_m_rt, stall_cnt
  );

  modport slave (
    input  d_rs, d_rt, d_a3, d_reg_write, d_rs_tuse, d_rt_tuse, d_tnew,
    output stall, fwd_d_rs, fwd_d_rt, fwd_e_rs, fwd_e_rt, fwd_m_rt, stall_cnt
  );
endinterface

// File: rtl/hazard_unit_fwd_sel.sv
// hazard_unit_fwd_sel: priority match of one consumer register against up
// to three producer stages, youngest (slot 0) first.
//   i_addr            - consumer register address
//   i_a3_N, i_tnew_N  - producer destination and remaining T_new, slot N
//   o_sel_c           - CODE_N of the youngest matching slot if its result
//                       is ready, else FWD_NONE (combinational)
// Unused slots are tied to a3 = 0, which never matches.
module hazard_unit_fwd_sel
  import hazard_unit_pkg::*;
#(
  parameter int unsigned REG_AW = 5,
  parameter fwd_sel_e    CODE_0 = FWD_E,
  parameter fwd_sel_e    CODE_1 = FWD_M,
  parameter fwd_sel_e    CODE_2 = FWD_W
) (
  input  logic [REG_AW-1:0] i_addr,
  input  logic [REG_AW-1:0] i_a3_0,
  input  logic [1:0]        i_tnew_0,
  input  logic [REG_AW-1:0] i_a3_1,
  input  logic [1:0]        i_tnew_1,
  input  logic [REG_AW-1:0] i_a3_2,
  input  logic [1:0]        i_tnew_2,
  output fwd_sel_e          o_sel_c
);

  logic w_hit_0;
  logic w_hit_1;
  logic w_hit_2;

  assign w_hit_0 = (i_a3_0 != '0) && (i_a3_0 == i_addr);
  assign w_hit_1 = (i_a3_1 != '0) && (i_a3_1 == i_addr);
  assign w_hit_2 = (i_a3_2 != '0) && (i_a3_2 == i_addr);

  // A younger match that is not ready yet masks older matches: their value
  // is stale, so the consumer keeps its default path.
  always_comb begin
    o_sel_c = FWD_NONE;
    if (w_hit_0) begin
      if (i_tnew_0 == 2'd0) o_sel_c = CODE_0;
    end else if (w_hit_1) begin
      if (i_tnew_1 == 2'd0) o_sel_c = CODE_1;
    end else if (w_hit_2) begin
      if (i_tnew_2 == 2'd0) o_sel_c = CODE_2;
    end
  end

endmodule

// File: rtl/hazard_unit.sv
// hazard_unit: T_use/T_new hazard resolution for the 5-stage P5 pipeline.
//   clk    - pipeline clock
//   reset  - synchronous, active-low; clears scoreboard and stall counter
//   bus    - hazard_unit_if.slave: D-stage tags in, stall/forwards/count out
// Keeps an E/M/W scoreboard (dest, remaining T_new, sources), raises the
// D-stage stall, drives every forwarding select and counts stall cycles.
module hazard_unit
  import hazard_unit_pkg::*;
#(
  parameter int unsigned REG_AW = 5,
  parameter int unsigned CNT_W  = 32
) (
  input  logic          clk,
  input  logic          reset,
  hazard_unit_if.slave  bus
);

  // Scoreboard
  logic [REG_AW-1:0] r_a3_e;
  logic [1:0]        r_tnew_e;
  logic [REG_AW-1:0] r_rs_e;
  logic [REG_AW-1:0] r_rt_e;
  logic [REG_AW-1:0] r_a3_m;
  logic [1:0]        r_tnew_m;
  logic [REG_AW-1:0] r_rt_m;
  logic [REG_AW-1:0] r_a3_w;
  logic [1:0]        r_tnew_w;
  logic [CNT_W-1:0]  r_stall_cnt;

  logic [REG_AW-1:0] w_eff_a3;
  logic              w_rs_haz;
  logic              w_rt_haz;
  logic              w_stall;

  fwd_sel_e w_fwd_d_rs;
  fwd_sel_e w_fwd_d_rt;
  fwd_sel_e w_fwd_e_rs;
  fwd_sel_e w_fwd_e_rt;
  fwd_sel_e w_fwd_m_rt;

  // Non-writing instructions are tracked as writing $0, which never matches.
  assign w_eff_a3 = bus.d_reg_write ? bus.d_a3 : '0;

  // Stall when a producer in E or M will not have its result by the time
  // the D-stage source is needed. W is always ready.
  assign w_rs_haz = (bus.d_rs != '0) && (bus.d_rs_tuse != T_USE_NONE) &&
                    (((r_a3_e == bus.d_rs) && (r_tnew_e > bus.d_rs_tuse)) ||
                     ((r_a3_m == bus.d_rs) && (r_tnew_m > bus.d_rs_tuse)));

  assign w_rt_haz = (bus.d_rt != '0) && (bus.d_rt_tuse != T_USE_NONE) &&
                    (((r_a3_e == bus.d_rt) && (r_tnew_e > bus.d_rt_tuse)) ||
                     ((r_a3_m == bus.d_rt) && (r_tnew_m > bus.d_rt_tuse)));

  assign w_stall = w_rs_haz || w_rt_haz;

  // Pipeline scoreboard: D->E (or bubble on stall), E->M, M->W.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_a3_e   <= '0;
      r_tnew_e <= '0;
      r_rs_e   <= '0;
      r_rt_e   <= '0;
      r_a3_m   <= '0;
      r_tnew_m <= '0;
      r_rt_m   <= '0;
      r_a3_w   <= '0;
      r_tnew_w <= '0;
    end else begin
      if (w_stall) begin
        r_a3_e   <= '0;
        r_tnew_e <= '0;
        r_rs_e   <= '0;
        r_rt_e   <= '0;
      end else begin
        r_a3_e   <= w_eff_a3;
        r_tnew_e <= tnew_dec(bus.d_tnew);
        r_rs_e   <= bus.d_rs;
        r_rt_e   <= bus.d_rt;
      end
      r_a3_m   <= r_a3_e;
      r_tnew_m <= tnew_dec(r_tnew_e);
      r_rt_m   <= r_rt_e;
      r_a3_w   <= r_a3_m;
      r_tnew_w <= tnew_dec(r_tnew_m);
    end
  end

  // Saturating stall-cycle counter.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_stall_cnt <= '0;
    end else if (w_stall && (r_stall_cnt != '1)) begin
      r_stall_cnt <= r_stall_cnt + CNT_W'(1);
    end
  end

  // D-stage consumers: E > M > W.
  hazard_unit_fwd_sel #(
    .REG_AW (REG_AW), .CODE_0 (FWD_E), .CODE_1 (FWD_M), .CODE_2 (FWD_W)
  ) u_fwd_d_rs (
    .i_addr   (bus.d_rs),
    .i_a3_0   (r_a3_e), .i_tnew_0 (r_tnew_e),
    .i_a3_1   (r_a3_m), .i_tnew_1 (r_tnew_m),
    .i_a3_2   (r_a3_w), .i_tnew_2 (r_tnew_w),
    .o_sel_c  (w_fwd_d_rs)
  );

  hazard_unit_fwd_sel #(
    .REG_AW (REG_AW), .CODE_0 (FWD_E), .CODE_1 (FWD_M), .CODE_2 (FWD_W)
  ) u_fwd_d_rt (
    .i_addr   (bus.d_rt),
    .i_a3_0   (r_a3_e), .i_tnew_0 (r_tnew_e),
    .i_a3_1   (r_a3_m), .i_tnew_1 (r_tnew_m),
    .i_a3_2   (r_a3_w), .i_tnew_2 (r_tnew_w),
    .o_sel_c  (w_fwd_d_rt)
  );

  // E-stage consumers: M > W.
  hazard_unit_fwd_sel #(
    .REG_AW (REG_AW), .CODE_0 (FWD_M), .CODE_1 (FWD_W), .CODE_2 (FWD_NONE)
  ) u_fwd_e_rs (
    .i_addr   (r_rs_e),
    .i_a3_0   (r_a3_m), .i_tnew_0 (r_tnew_m),
    .i_a3_1   (r_a3_w), .i_tnew_1 (r_tnew_w),
    .i_a3_2   ('0),     .i_tnew_2 (2'd0),
    .o_sel_c  (w_fwd_e_rs)
  );

  hazard_unit_fwd_sel #(
    .REG_AW (REG_AW), .CODE_0 (FWD_M), .CODE_1 (FWD_W), .CODE_2 (FWD_NONE)
  ) u_fwd_e_rt (
    .i_addr   (r_rt_e),
    .i_a3_0   (r_a3_m), .i_tnew_0 (r_tnew_m),
    .i_a3_1   (r_a3_w), .i_tnew_1 (r_tnew_w),
    .i_a3_2   ('0),     .i_tnew_2 (2'd0),
    .o_sel_c  (w_fwd_e_rt)
  );

  // M-stage consumer (store data): W only.
  hazard_unit_fwd_sel #(
    .REG_AW (REG_AW), .CODE_0 (FWD_W), .CODE_1 (FWD_NONE), .CODE_2 (FWD_NONE)
  ) u_fwd_m_rt (
    .i_addr   (r_rt_m),
    .i_a3_0   (r_a3_w), .i_tnew_0 (r_tnew_w),
    .i_a3_1   ('0),     .i_tnew_1 (2'd0),
    .i_a3_2   ('0),     .i_tnew_2 (2'd0),
    .o_sel_c  (w_fwd_m_rt)
  );

  assign bus.stall     = w_stall;
  assign bus.fwd_d_rs  = w_fwd_d_rs;
  assign bus.fwd_d_rt  = w_fwd_d_rt;
  assign bus.fwd_e_rs  = w_fwd_e_rs;
  assign bus.fwd_e_rt  = w_fwd_e_rt;
  assign bus.fwd_m_rt  = w_fwd_m_rt;
  assign bus.stall_cnt = r_stall_cnt;

endmodule

// File: tb/tb_hazard_unit.sv
// tb_hazard_unit: table-driven instruction stream with a scoreboard queue of
// expected stall/forward/counter values, plus reset-during-stall and
// counter-saturation sequences. Counter width is shrunk to 4 bits.
module tb_hazard_unit;

  localparam int unsigned REG_AW = 5;
  localparam int unsigned CNT_W  = 4;
  localparam int unsigned N_TBL  = 34;

  typedef struct {
    int               id;
    logic [4:0]       rs, rt, a3;
    logic             we;
    logic [1:0]       rs_tu, rt_tu, tnew;
    logic             stall;
    logic [1:0]       fdrs, fdrt, fers, fert, fmrt;
    logic [CNT_W-1:0] cnt;
    logic             chk_fwd;
  } vec_t;

  logic clk;
  logic reset;

  hazard_unit_if #(.REG_AW(REG_AW), .CNT_W(CNT_W)) hif ();

  hazard_unit #(.REG_AW(REG_AW), .CNT_W(CNT_W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (hif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  vec_t tbl [N_TBL];
  vec_t sb_q [$];
  int   n_vec  = 0;
  int   n_miss = 0;

  function automatic vec_t mk(input int id,
                              input logic [4:0] rs, input logic [1:0] rs_tu,
                              input logic [4:0] rt, input logic [1:0] rt_tu,
                              input logic [4:0] a3, input logic we,
                              input logic [1:0] tnew,
                              input logic st, input logic [1:0] fdrs,
                              input logic [1:0] fdrt, input logic [1:0] fers,
                              input logic [1:0] fert, input logic [1:0] fmrt,
                              input logic [CNT_W-1:0] cnt);
    vec_t v;
    v.id = id; v.rs = rs; v.rs_tu = rs_tu; v.rt = rt; v.rt_tu = rt_tu;
    v.a3 = a3; v.we = we; v.tnew = tnew; v.stall = st;
    v.fdrs = fdrs; v.fdrt = fdrt; v.fers = fers; v.fert = fert; v.fmrt = fmrt;
    v.cnt = cnt; v.chk_fwd = 1'b1;
    return v;
  endfunction

  function automatic vec_t nop(input int id, input logic [1:0] fers,
                               input logic [1:0] fert, input logic [1:0] fmrt,
                               input logic [CNT_W-1:0] cnt);
    return mk(id, 5'd0, 2'd3, 5'd0, 2'd3, 5'd0, 1'b0, 2'd0,
              1'b0, 2'd0, 2'd0, fers, fert, fmrt, cnt);
  endfunction

  task automatic apply(input vec_t v);
    hif.d_rs        = v.rs;
    hif.d_rt        = v.rt;
    hif.d_a3        = v.a3;
    hif.d_reg_write = v.we;
    hif.d_rs_tuse   = v.rs_tu;
    hif.d_rt_tuse   = v.rt_tu;
    hif.d_tnew      = v.tnew;
  endtask

  task automatic drive(input vec_t v);
    apply(v);
    sb_q.push_back(v);
  endtask

  task automatic check();
    vec_t e;
    logic bad;
    if (sb_q.size() == 0) begin
      n_vec++;
      n_miss++;
      $display("FAIL scoreboard_empty: no expected entry queued");
      return;
    end
    e = sb_q.pop_front();
    n_vec++;
    bad = (hif.stall !== e.stall) || (hif.stall_cnt !== e.cnt);
    if (e.chk_fwd)
      bad = bad || ({hif.fwd_d_rs, hif.fwd_d_rt, hif.fwd_e_rs, hif.fwd_e_rt,
                     hif.fwd_m_rt} !== {e.fdrs, e.fdrt, e.fers, e.fert, e.fmrt});
    if (bad) begin
      n_miss++;
      $display("FAIL vec%0d: got stall=%0d cnt=%0d fwd d_rs/d_rt/e_rs/e_rt/m_rt=%0d/%0d/%0d/%0d/%0d, want stall=%0d cnt=%0d fwd=%0d/%0d/%0d/%0d/%0d (fwd checked=%0d)",
               e.id, hif.stall, hif.stall_cnt, hif.fwd_d_rs, hif.fwd_d_rt,
               hif.fwd_e_rs, hif.fwd_e_rt, hif.fwd_m_rt, e.stall, e.cnt,
               e.fdrs, e.fdrt, e.fers, e.fert, e.fmrt, e.chk_fwd);
    end
  endtask

  // Drive at posedge+1, sample at posedge+5 (the falling edge).
  task automatic step(input vec_t v);
    drive(v);
    #4;
    check();
    @(posedge clk);
    #1;
  endtask

  initial begin
    vec_t v;
    int   exp_stalls;

    // id,  rs,tu, rt,tu, a3,we,tnew,  st,fdrs,fdrt,fers,fert,fmrt,cnt
    tbl[0]  = nop(0, 0, 0, 0, 0);
    // lw $1 then add $2,$1,$3: one-cycle stall, then W->E forward
    tbl[1]  = mk(1,  0,1,  1,3,  1,1,3,  0,0,0,0,0,0, 0);
    tbl[2]  = mk(2,  1,1,  3,1,  2,1,2,  1,0,0,0,0,0, 0);
    tbl[3]  = mk(3,  1,1,  3,1,  2,1,2,  0,0,0,0,0,0, 1);
    tbl[4]  = nop(4, 3, 0, 0, 1);
    tbl[5]  = nop(5, 0, 0, 0, 1);
    // add $4 then beq $4,$0: stall while add in E, then M->D forward
    tbl[6]  = mk(6,  0,1,  0,1,  4,1,2,  0,0,0,0,0,0, 1);
    tbl[7]  = mk(7,  4,0,  0,0,  0,0,0,  1,0,0,0,0,0, 1);
    tbl[8]  = mk(8,  4,0,  0,0,  0,0,0,  0,2,0,0,0,0, 2);
    tbl[9]  = nop(9, 3, 0, 0, 2);
    // jal then jr $31: E->D forward of PC+8, no stall
    tbl[10] = mk(10, 0,3,  0,3, 31,1,1,  0,0,0,0,0,0, 2);
    tbl[11] = mk(11,31,0,  0,3,  0,0,0,  0,1,0,0,0,0, 2);
    tbl[12] = nop(12, 2, 0, 0, 2);
    // add $5 then sw $5: M->E then W->M forward of store data
    tbl[13] = mk(13, 0,1,  0,1,  5,1,2,  0,0,0,0,0,0, 2);
    tbl[14] = mk(14, 0,1,  5,2,  0,0,0,  0,0,0,0,0,0, 2);
    tbl[15] = nop(15, 0, 2, 0, 2);
    tbl[16] = nop(16, 0, 0, 3, 2);
    // add $6, nop, sw $6: M->D then W->E
    tbl[17] = mk(17, 0,1,  0,1,  6,1,2,  0,0,0,0,0,0, 2);
    tbl[18] = nop(18, 0, 0, 0, 2);
    tbl[19] = mk(19, 0,1,  6,2,  0,0,0,  0,0,2,0,0,0, 2);
    tbl[20] = nop(20, 0, 3, 0, 2);
    // ori $0 then beq $0,$0: register 0 never stalls or forwards
    tbl[21] = mk(21, 0,1,  0,3,  0,1,2,  0,0,0,0,0,0, 2);
    tbl[22] = mk(22, 0,0,  0,0,  0,0,0,  0,0,0,0,0,0, 2);
    tbl[23] = nop(23, 0, 0, 0, 2);
    // ori $7 twice then sw $7: youngest match wins even when not ready
    tbl[24] = mk(24, 0,1,  0,3,  7,1,2,  0,0,0,0,0,0, 2);
    tbl[25] = mk(25, 0,1,  0,3,  7,1,2,  0,0,0,0,0,0, 2);
    tbl[26] = mk(26, 0,1,  7,2,  0,0,0,  0,0,0,0,0,0, 2);
    tbl[27] = nop(27, 0, 2, 0, 2);
    tbl[28] = nop(28, 0, 0, 3, 2);
    // lw $8, nop, beq $0,$8: rt stall from M, then W->D
    tbl[29] = mk(29, 0,1,  8,3,  8,1,3,  0,0,0,0,0,0, 2);
    tbl[30] = nop(30, 0, 0, 0, 2);
    tbl[31] = mk(31, 0,0,  8,0,  0,0,0,  1,0,0,0,0,0, 2);
    tbl[32] = mk(32, 0,0,  8,0,  0,0,0,  0,0,3,0,0,0, 3);
    tbl[33] = nop(33, 0, 0, 0, 3);

    reset = 1'b0;
    apply(nop(-1, 0, 0, 0, 0));
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;

    for (int i = 0; i < N_TBL; i++) step(tbl[i]);

    // Reset on the edge where lw $9 in E stalls add $10,$9,$0.
    step(mk(100, 0,1, 9,3, 9,1,3,  0,0,0,0,0,0, 3));
    v = mk(101, 9,1, 0,1, 10,1,2,  1,0,0,0,0,0, 3);
    drive(v);
    #4;
    check();
    reset = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b1;
    step(mk(102, 9,1, 0,1, 10,1,2,  0,0,0,0,0,0, 0));
    step(nop(103, 0, 0, 0, 0));

    // lw $1,0($1) repeated: stalls every other cycle; counter saturates.
    exp_stalls = 0;
    for (int k = 0; k < 40; k++) begin
      v = mk(200 + k, 1,1, 1,3, 1,1,3,  1'(k % 2), 0,0,0,0,0,
             (exp_stalls > 15) ? CNT_W'(15) : CNT_W'(exp_stalls));
      v.chk_fwd = 1'b0;
      step(v);
      if (k % 2 == 1) exp_stalls++;
    end

    if (sb_q.size() != 0) begin
      n_vec++;
      n_miss++;
      $display("FAIL scoreboard_drain: %0d expected entries left, want 0",
               sb_q.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
